// File: rtl/adc_pkt_framer.sv
// -----------------------------------------------------------------------------
// adc_pkt_framer
//
// Store-and-forward framer for a timestamped ADC word stream. Words between
// s_tfirst and s_tlast are buffered. Once the packet is complete, the block
// emits one header word, then the stored payload words, then an XOR-checksum
// trailer marked with m_tlast.
//
// Handshake semantics, on both sides: a beat transfers on a rising clk edge
// where valid && ready are both 1. A source never withdraws valid or changes
// data/last while its beat is waiting. s_tready is a registered function of
// the framer state only, so it never depends combinationally on m_tready.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   ena             framer enable (takes effect only in IDLE/FILL)
//   s_t*            input stream: tdata[63:0], tfirst, tlast, tvalid, tready
//   m_t*            output stream: tdata[63:0], tlast, tvalid, tready
//   pkt_count       saturating count of packets emitted (trailer transferred)
//   drop_count      saturating count of input words discarded
//   dbg_state       current FSM state (IDLE=0 FILL=1 HDR=2 PAY=3 TRL=4)
//
// Header word: {16'hCAFE, STREAM_ID, flags[7:0], seq[15:0], len[15:0]}
//   flags[0] truncated, flags[1] resync, others 0.
// -----------------------------------------------------------------------------
module adc_pkt_framer #(
  parameter logic [7:0] STREAM_ID = 8'hDD,
  parameter int         MAX_WORDS = 1024,
  parameter int         ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [63:0] s_tdata,
  input  logic        s_tfirst,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [2:0]  dbg_state
);

  localparam int LW = ADDR_BITS + 1;
  localparam logic [LW-1:0]        MAX_LEN = LW'(MAX_WORDS);
  localparam logic [LW-1:0]        ONE_L   = LW'(1);
  localparam logic [ADDR_BITS-1:0] ONE_A   = ADDR_BITS'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_TRL  = 3'd4
  } state_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Registers
  state_t                r_state;
  logic [LW-1:0]         r_len;       // stored words in current packet
  logic [LW-1:0]         r_out_cnt;   // payload words presented so far
  logic [ADDR_BITS-1:0]  r_rd_ptr;    // next buffer address to prefetch
  logic [15:0]           r_seq;
  logic                  r_trunc;
  logic                  r_resync;
  logic [63:0]           r_csum;
  logic [31:0]           r_pkt_count;
  logic [31:0]           r_drop_count;
  logic                  r_s_tready;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [63:0]           r_m_tdata;
  logic [63:0]           r_rd_data;
  logic [63:0]           r_mem [MAX_WORDS];

  // Combinational next-packet values for a beat accepted in IDLE/FILL
  logic                  w_in_fire;
  logic                  w_collect;
  logic                  w_we;
  logic [ADDR_BITS-1:0]  w_wr_addr;
  logic [LW-1:0]         w_nxt_len;
  logic [63:0]           w_nxt_csum;
  logic                  w_nxt_trunc;
  logic                  w_nxt_resync;
  logic [31:0]           w_drop_add;
  logic                  w_close;
  logic [63:0]           w_hdr;
  logic                  w_rd_en;
  logic [ADDR_BITS-1:0]  w_rd_addr;
  logic                  w_collecting_state;

  always_comb begin
    w_collecting_state = (r_state == ST_IDLE) || (r_state == ST_FILL);
    w_in_fire    = s_tvalid && r_s_tready;
    w_collect    = ena && w_in_fire && w_collecting_state;
    w_we         = 1'b0;
    w_wr_addr    = '0;
    w_nxt_len    = r_len;
    w_nxt_csum   = r_csum;
    w_nxt_trunc  = r_trunc;
    w_nxt_resync = r_resync;
    w_drop_add   = 32'd0;
    w_close      = 1'b0;
    if (w_collect) begin
      if (s_tfirst) begin
        // New packet start; in FILL this throws away the partial packet.
        w_we         = 1'b1;
        w_wr_addr    = '0;
        w_nxt_len    = ONE_L;
        w_nxt_csum   = s_tdata;
        w_nxt_trunc  = 1'b0;
        w_nxt_resync = (r_state == ST_FILL);
        w_drop_add   = (r_state == ST_FILL) ? 32'(r_len) : 32'd0;
        w_close      = s_tlast;
      end else if (r_state == ST_IDLE) begin
        w_drop_add   = 32'd1;
      end else if (r_len < MAX_LEN) begin
        w_we         = 1'b1;
        w_wr_addr    = r_len[ADDR_BITS-1:0];
        w_nxt_len    = r_len + ONE_L;
        w_nxt_csum   = r_csum ^ s_tdata;
        w_close      = s_tlast;
      end else begin
        // Buffer full: accept and discard until tlast closes the packet.
        w_drop_add   = 32'd1;
        w_nxt_trunc  = 1'b1;
        w_close      = s_tlast;
      end
    end
    w_hdr = {16'hCAFE, STREAM_ID, 6'b0, w_nxt_resync, w_nxt_trunc, r_seq, 16'(w_nxt_len)};

    // While collecting, keep word 0 prefetched so the first payload word is
    // ready the moment the header transfers. After that, advance one read
    // per output transfer so the read latency is always one word ahead.
    if (w_collecting_state) begin
      w_rd_en   = 1'b1;
      w_rd_addr = '0;
    end else begin
      w_rd_en   = r_m_tvalid && m_tready && (r_state == ST_HDR || r_state == ST_PAY);
      w_rd_addr = r_rd_ptr;
    end
  end

  // Payload buffer with registered read; a same-cycle write to the read
  // address is forwarded so a word-0 write is visible immediately.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= s_tdata;
    end
    if (w_rd_en) begin
      r_rd_data <= (w_we && (w_wr_addr == w_rd_addr)) ? s_tdata : r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_out_cnt    <= '0;
      r_rd_ptr     <= '0;
      r_seq        <= 16'd0;
      r_trunc      <= 1'b0;
      r_resync     <= 1'b0;
      r_csum       <= 64'd0;
      r_pkt_count  <= 32'd0;
      r_drop_count <= 32'd0;
      r_s_tready   <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FILL: begin
          r_rd_ptr   <= ONE_A;
          r_s_tready <= 1'b1;
          if (!ena) begin
            // Disabled: drop any partial packet plus the beat on the bus.
            r_drop_count <= sat_add(r_drop_count, 32'(r_len) + {31'b0, w_in_fire});
            r_len        <= '0;
            r_csum       <= 64'd0;
            r_trunc      <= 1'b0;
            r_resync     <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_drop_count <= sat_add(r_drop_count, w_drop_add);
            r_len        <= w_nxt_len;
            r_csum       <= w_nxt_csum;
            r_trunc      <= w_nxt_trunc;
            r_resync     <= w_nxt_resync;
            if (w_close) begin
              r_state    <= ST_HDR;
              r_s_tready <= 1'b0;
              r_m_tvalid <= 1'b1;
              r_m_tlast  <= 1'b0;
              r_m_tdata  <= w_hdr;
            end else if (w_collect && s_tfirst) begin
              r_state    <= ST_FILL;
            end
          end
        end
        ST_HDR: begin
          if (m_tready) begin
            r_m_tdata <= r_rd_data;
            r_rd_ptr  <= r_rd_ptr + ONE_A;
            r_out_cnt <= ONE_L;
            r_state   <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (m_tready) begin
            if (r_out_cnt == r_len) begin
              r_m_tdata <= r_csum;
              r_m_tlast <= 1'b1;
              r_state   <= ST_TRL;
            end else begin
              r_m_tdata <= r_rd_data;
              r_rd_ptr  <= r_rd_ptr + ONE_A;
              r_out_cnt <= r_out_cnt + ONE_L;
            end
          end
        end
        ST_TRL: begin
          if (m_tready) begin
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tdata   <= 64'd0;
            r_pkt_count <= sat_add(r_pkt_count, 32'd1);
            r_seq       <= r_seq + 16'd1;
            r_trunc     <= 1'b0;
            r_resync    <= 1'b0;
            r_len       <= '0;
            r_csum      <= 64'd0;
            r_s_tready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_tready   = r_s_tready;
  assign m_tdata    = r_m_tdata;
  assign m_tlast    = r_m_tlast;
  assign m_tvalid   = r_m_tvalid;
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_adc_pkt_framer.sv
// -----------------------------------------------------------------------------
// tb_adc_pkt_framer
//
// Directed and randomized stimulus for adc_pkt_framer. Expected output words
// come from a packet-level model: input beats are collected into a word list,
// and on tlast the frame (header, words, XOR trailer) is appended to exp_q.
// A monitor compares every output transfer and checks that data holds during
// stalls.
// -----------------------------------------------------------------------------
module tb_adc_pkt_framer;

  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [63:0] s_tdata = 64'd0;
  logic        s_tfirst = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {last, data}
  logic [64:0] exp_q[$];

  // Packet-level reference model state
  logic [63:0] m_words[$];
  bit          m_in_pkt = 0;
  bit          m_trunc = 0;
  bit          m_resync = 0;
  int unsigned m_drop = 0;
  int unsigned m_pkts = 0;

  bit rand_ready = 0;

  adc_pkt_framer #(.STREAM_ID(8'hDD), .MAX_WORDS(MAXW), .ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .s_tdata(s_tdata), .s_tfirst(s_tfirst), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .pkt_count(pkt_count), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_clear();
    m_words.delete();
    m_in_pkt = 0;
    m_trunc  = 0;
    m_resync = 0;
    m_drop   = 0;
    m_pkts   = 0;
    exp_q.delete();
  endtask

  task automatic model_ena_off();
    m_drop += m_words.size();
    m_words.delete();
    m_in_pkt = 0;
    m_trunc  = 0;
    m_resync = 0;
  endtask

  task automatic model_beat(input logic [63:0] d, input logic f, input logic l);
    logic [63:0] x;
    if (!ena) begin
      model_ena_off();
      m_drop += 1;
      return;
    end
    if (f) begin
      if (m_in_pkt) begin
        m_drop  += m_words.size();
        m_resync = 1;
      end else begin
        m_resync = 0;
      end
      m_trunc = 0;
      m_words.delete();
      m_words.push_back(d);
      m_in_pkt = 1;
    end else if (!m_in_pkt) begin
      m_drop += 1;
    end else if (m_words.size() < MAXW) begin
      m_words.push_back(d);
    end else begin
      m_drop += 1;
      m_trunc = 1;
    end
    if (l && m_in_pkt) begin
      x = 64'd0;
      exp_q.push_back({1'b0, 16'hCAFE, 8'hDD, 6'b0, m_resync, m_trunc,
                       16'(m_pkts % 65536), 16'(m_words.size())});
      foreach (m_words[i]) begin
        exp_q.push_back({1'b0, m_words[i]});
        x ^= m_words[i];
      end
      exp_q.push_back({1'b1, x});
      m_pkts++;
      m_words.delete();
      m_in_pkt = 0;
      m_trunc  = 0;
      m_resync = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [63:0] d, input logic f, input logic l);
    bit got;
    got = 0;
    s_tdata  = d;
    s_tfirst = f;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (s_tready === 1'b1) got = 1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    if (got) model_beat(d, f, l);
    else chk("s_tready_timeout", {63'b0, got}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10000 && exp_q.size() != 0; i++) tick();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    tick();
    tick();
    model_clear();
    rst = 1'b0;
    tick();
  endtask

  // Downstream ready: constantly 1, or random stalls
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare and stall stability
  initial begin
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [64:0] e;
    prev_stall = 0;
    prev_data  = 64'd0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", {63'b0, m_tvalid}, 64'd1);
          chk("stall_data_held", m_tdata, prev_data);
          chk("stall_last_held", {63'b0, m_tlast}, {63'b0, prev_last});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_out_beat observed=%h expected=no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_tdata, e[63:0]);
            chk("out_last", {63'b0, m_tlast}, {63'b0, e[64]});
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] a, b, c;
    int n;

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_s_tready", {63'b0, s_tready}, 64'd0);
    chk("rst_m_tvalid", {63'b0, m_tvalid}, 64'd0);
    chk("rst_m_tlast", {63'b0, m_tlast}, 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_tready", {63'b0, s_tready}, 64'd1);

    // 3-word packet A,B,C with m_tready=1
    a = rnd64(); b = rnd64(); c = rnd64();
    send_beat(a, 1'b1, 1'b0);
    send_beat(b, 1'b0, 1'b0);
    send_beat(c, 1'b0, 1'b1);
    chk("hdr_latency_valid", {63'b0, m_tvalid}, 64'd1);
    chk("hdr_3word", m_tdata, 64'hCAFE_DD00_0000_0003);
    chk("hdr_3word_last", {63'b0, m_tlast}, 64'd0);
    chk("s_tready_low_hdr", {63'b0, s_tready}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_bubble_valid", {63'b0, m_tvalid}, 64'd1);
      chk("no_bubble_last", {63'b0, m_tlast}, {63'b0, (i == 4)});
      if (i == 4) chk("trailer_xor", m_tdata, a ^ b ^ c);
      @(posedge clk);
      #1;
    end
    chk("after_trl_valid", {63'b0, m_tvalid}, 64'd0);
    chk("pkt_count_1", 64'(pkt_count), 64'd1);
    chk("s_tready_after_trl", {63'b0, s_tready}, 64'd1);
    chk("exp_q_empty_3w", 64'(exp_q.size()), 64'd0);

    // Two one-word packets: seq 0 then 1, then run until seq wraps
    do_reset();
    send_beat(rnd64(), 1'b1, 1'b1);
    chk("one_word_seq0", {48'b0, m_tdata[31:16]}, 64'd0);
    chk("one_word_len1", {48'b0, m_tdata[15:0]}, 64'd1);
    send_beat(rnd64(), 1'b1, 1'b1);
    chk("one_word_seq1", {48'b0, m_tdata[31:16]}, 64'd1);
    for (int p = 2; p < 65536 && errors == 0; p++) begin
      send_beat(rnd64(), 1'b1, 1'b1);
    end
    send_beat(rnd64(), 1'b1, 1'b1);
    chk("seq_wrap_hdr", {48'b0, m_tdata[31:16]}, 64'd0);
    wait_drain();
    chk("pkt_count_wrap", 64'(pkt_count), 64'd65537);

    // 1030-word packet into a 1024-word buffer
    do_reset();
    for (int i = 0; i < 1030; i++) send_beat(rnd64(), (i == 0), (i == 1029));
    chk("trunc_hdr", m_tdata, 64'hCAFE_DD01_0000_0400);
    wait_drain();
    chk("trunc_drop_6", 64'(drop_count), 64'd6);
    chk("trunc_pkt_count", 64'(pkt_count), 64'd1);

    // tfirst after 5 buffered words
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(rnd64(), (i == 0), 1'b0);
    send_beat(rnd64(), 1'b1, 1'b0);
    chk("resync_drop_5", 64'(drop_count), 64'd5);
    send_beat(rnd64(), 1'b0, 1'b0);
    send_beat(rnd64(), 1'b0, 1'b1);
    chk("resync_flags", {56'b0, m_tdata[39:32]}, 64'h02);
    chk("resync_len", {48'b0, m_tdata[15:0]}, 64'd3);
    wait_drain();

    // Random traffic with random downstream stalls
    rand_ready = 1;
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 5) == 0) send_beat(rnd64(), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        send_beat(rnd64(), 1'b1, 1'b0);
        send_beat(rnd64(), 1'b0, 1'b0);
      end
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) send_beat(rnd64(), (i == 0), (i == n - 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    wait_drain();
    chk("rand_pkt_count", 64'(pkt_count), 64'(m_pkts));
    chk("rand_drop_count", 64'(drop_count), 64'(m_drop));
    rand_ready = 0;
    tick();

    // ena=0 in FILL discards the partial packet and following beats
    send_beat(rnd64(), 1'b1, 1'b0);
    send_beat(rnd64(), 1'b0, 1'b0);
    send_beat(rnd64(), 1'b0, 1'b0);
    ena = 1'b0;
    tick();
    model_ena_off();
    chk("ena_off_s_tready", {63'b0, s_tready}, 64'd1);
    send_beat(rnd64(), 1'b1, 1'b1);
    chk("ena_off_no_output", {63'b0, m_tvalid}, 64'd0);
    chk("ena_off_drop", 64'(drop_count), 64'(m_drop));
    ena = 1'b1;
    tick();
    send_beat(rnd64(), 1'b1, 1'b0);
    send_beat(rnd64(), 1'b0, 1'b1);
    // Dropping ena mid-output must let the packet finish
    ena = 1'b0;
    wait_drain();
    chk("ena_off_pkt_completes", 64'(pkt_count), 64'(m_pkts));
    ena = 1'b1;
    tick();

    // Stray beats in IDLE, then reset in the middle of PAY
    do_reset();
    send_beat(rnd64(), 1'b0, 1'b0);
    send_beat(rnd64(), 1'b0, 1'b1);
    chk("idle_stray_drop_2", 64'(drop_count), 64'd2);
    for (int i = 0; i < 4; i++) send_beat(rnd64(), (i == 0), (i == 3));
    tick();
    tick();
    chk("mid_pay_valid", {63'b0, m_tvalid}, 64'd1);
    rst = 1'b1;
    tick();
    model_clear();
    chk("mid_rst_m_tvalid", {63'b0, m_tvalid}, 64'd0);
    chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
    chk("mid_rst_s_tready", {63'b0, s_tready}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_beat", {63'b0, m_tvalid}, 64'd0);
    end
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_pkt_framer.md
ADC_PKT_FRAMER -- requirements
Module: adc_pkt_framer

Interface
REQ-001 Parameters SHALL be:
- STREAM_ID, 8'hDD, ID placed in every header.
- MAX_WORDS, 1024, payload buffer capacity in 64-bit words.
- ADDR_BITS, 10, buffer address width; MAX_WORDS SHALL equal 2**ADDR_BITS.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- ena  in  1  framer enable.
- s_tdata  in  64  payload word from the timestamped ADC stream FIFO.
- s_tfirst  in  1  first word of a packet.
- s_tlast  in  1  last word of a packet.
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input word accepted.
- m_tdata  out  64  framed output word.
- m_tlast  out  1  last word of a framed packet (the trailer).
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream ready.
- pkt_count  out  32  packets emitted.
- drop_count  out  32  input words discarded.

Function
REQ-003 An input beat SHALL transfer when s_tvalid && s_tready; an output beat SHALL transfer when m_tvalid && m_tready.
REQ-004 The FSM SHALL have states IDLE, FILL, HDR, PAY and TRL; operation is store-and-forward, so nothing is emitted until a whole packet is buffered.
REQ-005 s_tready SHALL be 1 in IDLE and FILL, and 0 in HDR, PAY and TRL.
REQ-006 In IDLE, an accepted beat with s_tfirst=1 SHALL be written to buffer address 0 and the FSM SHALL go to FILL. An accepted beat with s_tfirst=0 SHALL be discarded and SHALL increment drop_count.
REQ-007 In FILL, each accepted beat SHALL be written at the next address and the word count (len) SHALL be incremented. The running XOR checksum SHALL be updated with every stored word.
REQ-008 In FILL, an accepted beat with s_tfirst=1 SHALL:
- discard the words already buffered and add their count to drop_count;
- set the sticky resync flag;
- restart the packet with this word at address 0.
REQ-009 When len reaches MAX_WORDS, further beats in FILL SHALL be accepted but not stored, SHALL increment drop_count, and SHALL set the truncated flag.
REQ-010 In FILL, an accepted beat with s_tlast=1 SHALL end the packet and move the FSM to HDR on the next cycle. A beat carrying both s_tfirst and s_tlast SHALL form a one-word packet.
REQ-011 The packet boundary SHALL be set by tlast only. A missing tlast SHALL never auto-close the packet.
REQ-012 The header word SHALL be {16'hCAFE, STREAM_ID, flags[7:0], seq[15:0], len[15:0]}, with:
- flags[0] = truncated;
- flags[1] = resync;
- flags[7:2] = 0;
- len = number of stored words, range 1..MAX_WORDS.
REQ-013 m_tvalid SHALL assert with the header exactly 1 cycle after the tlast input beat.
REQ-014 PAY SHALL emit the stored words in address order from 0 to len-1, with no bubbles while m_tready=1. The 1-cycle buffer read latency SHALL be hidden by prefetching the next word.
REQ-015 TRL SHALL emit the checksum (XOR of all stored payload words) with m_tlast=1. m_tlast SHALL be 0 on every other word.
REQ-016 While m_tvalid && !m_tready, m_tdata and m_tlast SHALL hold stable. m_tvalid SHALL NOT deassert until the beat transfers.
REQ-017 On trailer transfer, the block SHALL:
- increment pkt_count;
- increment seq, wrapping 16'hFFFF to 0;
- clear the flags;
- return the FSM to IDLE.
The block SHALL be ready for input on the next cycle.
REQ-018 The counters SHALL saturate: pkt_count and drop_count hold at 32'hFFFFFFFF.
REQ-019 When ena=0 in IDLE or FILL:
- s_tready SHALL be 1;
- every valid beat SHALL be discarded and counted in drop_count;
- any partial packet SHALL be discarded, with its words added to drop_count;
- the FSM SHALL go to IDLE.
When ena=0 in HDR, PAY or TRL, the packet in progress SHALL complete before ena takes effect.
REQ-020 All outputs SHALL be registered. There SHALL be no combinational path from m_tready to s_tready.

Reset
REQ-021 While rst=1:
- the FSM SHALL be in IDLE;
- s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0;
- pkt_count=0, drop_count=0;
- seq=0, len=0, flags=0, checksum=0.
s_tready SHALL be 1 on the first cycle after rst deasserts, if ena=1.
REQ-022 An rst asserted mid-packet, in any state, SHALL abandon that packet without emitting any further beat.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- 3-word packet A,B,C with m_tready=1 -> header {CAFE,DD,00,0000,0003}, then A, B, C, then trailer A^B^C with m_tlast; pkt_count=1.
- Two one-word packets -> seq values 0 and 1; 65536 packets -> seq wraps to 0.
- 1030-word packet with MAX_WORDS=1024 -> len=1024, flags=01, drop_count=6.
- tfirst after 5 buffered words -> drop_count=5; the next header has flags=02.
- Random m_tready stalls -> data matches the scoreboard; no word changes while stalled.
- 2 beats without tfirst in IDLE, then rst asserted mid-PAY -> drop_count=2 before reset; m_tvalid=0 and counters=0 after reset.
